// File: rtl/time_set_ctrl.sv
// Time/date set sequencer: captures cur_time, edits NUM_FIELDS fields MSB-first with
// wrap-around and hold-to-repeat, then pulses commit (last field confirmed) or abort (inactivity).
module time_set_ctrl #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 6,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = {6'd23, 6'd59, 6'd59},
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 12_500_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          set_btn,
  input  logic                          inc_btn,
  input  logic                          dec_btn,
  input  logic [NUM_FIELDS*FIELD_W-1:0] cur_time,
  output logic [NUM_FIELDS*FIELD_W-1:0] edit_val,
  output logic [NUM_FIELDS-1:0]         field_sel,
  output logic                          setting,
  output logic                          commit,
  output logic                          abort,
  output logic                          blink
);
  localparam int VW   = NUM_FIELDS * FIELD_W;
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [RW-1:0] DLY_C  = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] PER_C  = RW'(REPEAT_PER);
  localparam logic [TW-1:0] TO_LST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT, ABORT} state_t;
  state_t state, state_nxt;

  logic          set_q, inc_q, dec_q;
  logic          set_rise, one_btn, one_rise, rep_step, step, evt, to_hit;
  logic [RW-1:0] rep_cnt;
  logic          rep_on;
  logic [TW-1:0] to_cnt;
  logic [VW-1:0] val_nxt;
  logic [NUM_FIELDS-1:0] sel_nxt;

  function automatic logic [FIELD_W-1:0] bump(input logic [FIELD_W-1:0] v,
                                              input logic [FIELD_W-1:0] mx,
                                              input logic up);
    if (up) return (v >= mx) ? '0 : v + FIELD_W'(1);
    else    return (v == '0 || v > mx) ? mx : v - FIELD_W'(1);
  endfunction

  // Exactly one of inc/dec drives stepping; both together is treated as no button.
  assign set_rise = set_btn & ~set_q;
  assign one_btn  = inc_btn ^ dec_btn;
  assign one_rise = (inc_btn & ~dec_btn & ~inc_q) | (dec_btn & ~inc_btn & ~dec_q);
  assign rep_step = one_btn & ~one_rise & (rep_on ? (rep_cnt == PER_C) : (rep_cnt == DLY_C));
  assign step     = (state == EDIT) & (one_rise | rep_step);
  assign evt      = (state == EDIT) & (set_rise | step);
  assign to_hit   = (state == EDIT) & ~evt & tick & (to_cnt == TO_LST);

  always_comb begin
    state_nxt = state;
    val_nxt   = edit_val;
    sel_nxt   = field_sel;
    case (state)
      IDLE: begin
        if (set_rise) begin
          state_nxt = EDIT;
          val_nxt   = cur_time;
          sel_nxt   = '0;
          sel_nxt[NUM_FIELDS-1] = 1'b1;
        end
      end
      EDIT: begin
        if (set_rise) begin
          if (field_sel[0]) begin
            state_nxt = COMMIT;
            sel_nxt   = '0;
          end else begin
            sel_nxt = field_sel >> 1;
          end
        end else begin
          if (step) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
              if (field_sel[i])
                val_nxt[i*FIELD_W +: FIELD_W] = bump(edit_val[i*FIELD_W +: FIELD_W],
                                                     FIELD_MAX[i*FIELD_W +: FIELD_W], inc_btn);
            end
          end
          if (to_hit) begin
            state_nxt = ABORT;
            sel_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      edit_val  <= '0;
      field_sel <= '0;
      setting   <= 1'b0;
      commit    <= 1'b0;
      abort     <= 1'b0;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      edit_val  <= val_nxt;
      field_sel <= sel_nxt;
      setting   <= (state_nxt != IDLE);
      commit    <= (state_nxt == COMMIT);
      abort     <= (state_nxt == ABORT);
      blink     <= (state_nxt == EDIT && state == EDIT) ? (blink ^ tick) : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      set_q <= set_btn;
      inc_q <= inc_btn;
      dec_q <= dec_btn;
    end
  end

  // rep_cnt holds cycles since the press (or last step); rep_on selects first-delay vs period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else if (state != EDIT || !one_btn) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else if (one_rise || rep_step) begin
      rep_cnt <= RW'(1);
      rep_on  <= rep_step;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         to_cnt <= '0;
    else if (state != EDIT || evt)   to_cnt <= '0;
    else if (tick)                   to_cnt <= to_cnt + TW'(1);
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random stimulus, every cycle scored
// against a field-level behavioural model through an expected-output queue.
module tb_time_set_ctrl;
  localparam int NF = 3, FW = 6, DLY = 4, PER = 2, TO = 3;
  localparam logic [NF*FW-1:0] FMAX = {6'd23, 6'd59, 6'd59};

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, set_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic [NF*FW-1:0] cur_time = '0;
  logic [NF*FW-1:0] edit_val;
  logic [NF-1:0]    field_sel;
  logic setting, commit, abort, blink;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .FIELD_MAX(FMAX),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_btn(set_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .cur_time(cur_time), .edit_val(edit_val), .field_sel(field_sel),
    .setting(setting), .commit(commit), .abort(abort), .blink(blink)
  );

  typedef struct packed {
    logic [NF*FW-1:0] val;
    logic [NF-1:0]    sel;
    logic setting, commit, abort, blink;
  } obs_t;

  obs_t exp_q[$];
  int tests = 0, fails = 0;

  // Model: mode 0 idle, 1 edit, 2 commit, 3 abort; fields as plain integers.
  int m_mode = 0, m_sel = -1, m_to = 0, m_run = -1, cyc = 0;
  int m_val[NF] = '{0, 0, 0};
  int fmax[NF] = '{59, 59, 23};
  bit m_blink = 0, p_set = 0, p_inc = 0, p_dec = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    for (int k = 0; k < NF; k++) o.val[k*FW +: FW] = FW'(m_val[k]);
    if (m_sel >= 0) o.sel[m_sel] = 1'b1;
    o.setting = (m_mode != 0);
    o.commit  = (m_mode == 2);
    o.abort   = (m_mode == 3);
    o.blink   = m_blink;
    return o;
  endfunction

  task automatic model_cycle(input bit r, input bit s, input bit i, input bit d, input bit t,
                             input logic [NF*FW-1:0] cur);
    bit sr, one, orise, stp, evt;
    int age, nmode;
    cyc++;
    if (r) begin
      m_mode = 0; m_sel = -1; m_to = 0; m_run = -1; m_blink = 0;
      m_val = '{0, 0, 0};
      p_set = 0; p_inc = 0; p_dec = 0;
    end else begin
      sr    = s && !p_set;
      one   = i ^ d;
      orise = (i && !d && !p_inc) || (d && !i && !p_dec);
      stp   = 0;
      // A hold run starts at its press (or first single-button cycle in edit); steps at DLY, DLY+PER, ...
      if (m_mode == 1 && one) begin
        if (orise || m_run < 0) begin
          m_run = cyc;
          stp = orise;
        end else begin
          age = cyc - m_run;
          stp = (age == DLY) || (age > DLY && (age - DLY) % PER == 0);
        end
      end else begin
        m_run = -1;
      end
      evt = (m_mode == 1) && (sr || stp);
      nmode = m_mode;
      case (m_mode)
        0: if (sr) begin
             nmode = 1;
             for (int k = 0; k < NF; k++) m_val[k] = int'(cur[k*FW +: FW]);
             m_sel = NF - 1;
             m_to = 0;
           end
        1: begin
             if (sr) begin
               if (m_sel == 0) begin nmode = 2; m_sel = -1; end
               else m_sel = m_sel - 1;
             end else if (stp) begin
               if (i) m_val[m_sel] = (m_val[m_sel] >= fmax[m_sel]) ? 0 : m_val[m_sel] + 1;
               else   m_val[m_sel] = (m_val[m_sel] == 0 || m_val[m_sel] > fmax[m_sel]) ?
                                     fmax[m_sel] : m_val[m_sel] - 1;
             end
             if (evt) m_to = 0;
             else if (t) begin
               m_to++;
               if (m_to >= TO) begin nmode = 3; m_sel = -1; end
             end
           end
        default: nmode = 0;
      endcase
      m_blink = (nmode == 1 && m_mode == 1) ? (m_blink ^ t) : 1'b0;
      m_mode = nmode;
      p_set = s; p_inc = i; p_dec = d;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit i, input bit d, input bit t);
    rst = r; set_btn = s; inc_btn = i; dec_btn = d; tick = t;
    model_cycle(r, s, i, d, t, cur_time);
    exp_q.push_back(model_obs());
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {edit_val, field_sel, setting, commit, abort, blink};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_%0d: got val=%h sel=%b set=%b c=%b a=%b bl=%b, expected val=%h sel=%b set=%b c=%b a=%b bl=%b",
                 cyc, a.val, a.sel, a.setting, a.commit, a.abort, a.blink,
                 e.val, e.sel, e.setting, e.commit, e.abort, e.blink);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit il, dl;
    @(negedge clk); #1;
    step(1, 0, 0, 0, 0);
    chk("reset_outputs", {edit_val, field_sel, setting, commit, abort, blink}, 32'd0);

    // Asynchronous reset in the middle of editing
    step(0, 0, 0, 0, 0);
    cur_time = {6'd5, 6'd6, 6'd7};
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre_rst_inc", edit_val, {6'd6, 6'd6, 6'd7});
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_async", {edit_val, field_sel, setting, commit, abort, blink}, 32'd0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("inc_after_rst", edit_val, 32'd0);
    step(0, 0, 0, 0, 0);

    // Full edit/commit sequence from {23,59,58}
    cur_time = {6'd23, 6'd59, 6'd58};
    step(0, 1, 0, 0, 0);
    chk("capture_val", edit_val, {6'd23, 6'd59, 6'd58});
    chk("capture_sel", field_sel, 3'b100);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("hours_wrap", edit_val, {6'd0, 6'd59, 6'd58});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("min_dec", edit_val, {6'd0, 6'd58, 6'd58});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("sec_wrap", edit_val, {6'd0, 6'd58, 6'd0});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("commit_pulse", {commit, setting, abort}, 3'b110);
    chk("commit_val", edit_val, {6'd0, 6'd58, 6'd0});
    step(0, 0, 0, 0, 0);
    chk("after_commit", {commit, setting, field_sel}, 5'b0);
    chk("val_held", edit_val, {6'd0, 6'd58, 6'd0});

    // Clamp/wrap of out-of-range and zero values, simultaneous buttons, set+inc
    cur_time = {6'd30, 6'd0, 6'd59};
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("oor_inc", edit_val, {6'd0, 6'd0, 6'd59});
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("oor_dec", edit_val, {6'd23, 6'd0, 6'd59});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("zero_dec", edit_val, {6'd23, 6'd59, 6'd59});
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("inc_dec_both", edit_val, {6'd23, 6'd59, 6'd59});
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("set_inc_sel", field_sel, 3'b001);
    chk("set_inc_val", edit_val, {6'd23, 6'd59, 6'd59});
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("sec_inc_wrap", edit_val, {6'd23, 6'd59, 6'd0});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Hold-to-repeat: press step plus repeats at 4, 6, 8 cycles
    cur_time = {6'd10, 6'd20, 6'd30};
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("hold_repeat", edit_val[17:12], 6'd14);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Inactivity timeout, then the same with a button on the final tick
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("timeout_abort", {abort, commit, setting}, 3'b101);
    step(0, 0, 0, 0, 0);
    chk("after_abort", {abort, setting, field_sel}, 5'b0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("timeout_saved", {abort, setting}, 2'b01);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("timeout_restart", {abort, setting}, 2'b01);

    // Random traffic
    il = 0; dl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) il = !il;
      if ($urandom_range(0, 5) == 0) dl = !dl;
      cur_time = NF*FW'($urandom);
      step($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0, il, dl,
           $urandom_range(0, 3) == 0);
    end
    step(0, 0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Parametrised time/date setting controller for the digital clock. It captures the live time value and lets the user step through NUM_FIELDS fields, incrementing or decrementing each with wrap-around and hold-to-repeat. It then commits the edited value to the timekeeping registers, or aborts after an inactivity timeout. It sits between the debounced button front end and the time/alarm/calendar load logic, and is the single sequencer for every set mode of the clock.

## Interface
- NUM_FIELDS, 3: number of editable fields; field NUM_FIELDS-1 occupies the MSB slice and is edited first.
- FIELD_W, 6: width of each field.
- FIELD_MAX, {6'd23,6'd59,6'd59}: packed NUM_FIELDS*FIELD_W maximum value per field, with field 0 in the LSB slice.
- REPEAT_DLY, 50_000_000: clk cycles a button is held before auto-repeat starts.
- REPEAT_PER, 12_500_000: clk cycles between auto-repeat steps.
- TIMEOUT_TICKS, 30: `tick` strobes without a button event before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz strobe.
- set_btn  in  1  debounced level; the rising edge is the event.
- inc_btn  in  1  debounced level.
- dec_btn  in  1  debounced level.
- cur_time  in  NUM_FIELDS*FIELD_W  live value, captured on entry.
- edit_val  out  NUM_FIELDS*FIELD_W  working value (registered).
- field_sel  out  NUM_FIELDS  one-hot active field; all zero when not editing.
- setting  out  1  high while in EDIT or COMMIT/ABORT.
- commit  out  1  one-cycle pulse; edit_val is valid to load.
- abort  out  1  one-cycle pulse; timeout, nothing to load.
- blink  out  1  toggles on each `tick` while editing; 0 otherwise.

## Operation
- All outputs are registered. Reset values: state IDLE, edit_val 0, field_sel 0, setting 0, commit 0, abort 0, blink 0. All counters and edge-detect registers are cleared to 0.
- The FSM has four states: IDLE, EDIT, COMMIT, ABORT.
- IDLE:
  - A set_btn rising edge captures cur_time into edit_val, selects field NUM_FIELDS-1 and moves to EDIT.
  - inc_btn and dec_btn are ignored.
- EDIT, inc event: the active field becomes 0 if its value >= its max, else value+1.
- EDIT, dec event: the active field becomes its max if its value is 0 or > its max, else value-1.
- EDIT, inc and dec active together: no change; the repeat counters are cleared.
- EDIT, set_btn rising edge:
  - If field_sel is not field 0, the selection shifts right by one.
  - If field_sel is field 0, the FSM moves to COMMIT.
  - set_btn takes priority over inc/dec in the same cycle; inc/dec is dropped.
- A button event is a rising edge, or an auto-repeat step. Auto-repeat starts once a button has been held REPEAT_DLY cycles; after that a step occurs every REPEAT_PER cycles while the button is held. Releasing the button resets the repeat counter.
- Timeout counter:
  - Cleared on entry to EDIT and on every button event, including repeat steps.
  - Incremented on `tick`.
  - Reaching TIMEOUT_TICKS moves the FSM to ABORT.
  - If a button event and the final tick coincide, the button wins and no abort occurs.
- COMMIT: commit=1 for one cycle, then IDLE. edit_val is held unchanged until the next capture.
- ABORT: abort=1 for one cycle, then IDLE.
- field_sel is cleared on entry to COMMIT or ABORT.
- Field arithmetic is unsigned FIELD_W bits; out-of-range captured values are loaded unmodified.

## Timing
- A set_btn edge sampled at edge n in IDLE gives setting=1, the loaded edit_val and field_sel=MSB field after edge n.
- An inc/dec edge sampled at edge n updates edit_val after edge n (1-cycle latency).
- A set_btn edge on field 0 at edge n gives commit=1 in cycle n+1 with setting=1. In cycle n+2, commit=0 and setting=0.
- A first repeat step occurs REPEAT_DLY cycles after the press edge.
- A mid-operation reset returns the block to IDLE immediately (asynchronously) with no commit and no abort pulse.

## Test plan
- Reset during EDIT: all outputs 0, state IDLE; a following inc_btn edge has no effect on edit_val.
- With cur_time={23,59,58}: set; inc ×1 → hours 0; set; dec ×1 → minutes 58; set; inc ×2 → seconds 0 (wraps 58→59→0); set → commit pulse with edit_val={0,58,0}, then setting=0.
- Wrap/clamp: a field value of 0 with dec gives its max; a loaded hours value of 30 with inc gives 0, and with dec gives 23.
- Hold inc with REPEAT_DLY=4, REPEAT_PER=2, held 10 cycles → 1 edge step plus repeat steps at cycles 4, 6, 8 → +4 total.
- Simultaneous inc+dec → edit_val unchanged; set+inc in the same cycle → field advances and the value is unchanged.
- Timeout with TIMEOUT_TICKS=3: enter EDIT and apply 3 ticks with no buttons → abort pulse, no commit, setting drops; repeat with an inc on the 3rd tick → no abort.
